cbx_param_cfg: RTL
==================

Name: cbx_param_cfg

Overview:
- Parametrised successor to the fixed X-channel connection blocks.
- Channel width, ipin count and mux size are generics.
- Contains its own configuration-chain controller: shift counter, load state machine and done flag.
- Gates ipin outputs to 0 until a full configuration has been shifted in.
- Sits between two horizontal channel segments and the adjacent grid tiles; it is one link in the global ccff chain.

Parameters:
- CHAN_WIDTH, 10: tracks per direction; must be divisible by MUX_SIZE/2.
- NUM_IPIN, 11: number of grid input pins driven.
- MUX_SIZE, 4: inputs per ipin mux; power of 2, at least 2.
- SEL_W, $clog2(MUX_SIZE): select bits per ipin (derived).
- CHAIN_LEN, NUM_IPIN*SEL_W: configuration bits held (derived).
- GATE_UNCONF, 1: 1 means ipin_out is forced to 0 unless state is CONF; 0 means no gating.

Ports:
- prog_clk  in  1  configuration clock.
- pReset  in  1  asynchronous, active-low reset.
- ccff_head  in  1  serial configuration data in.
- cfg_en  in  1  shift enable; one chain bit per prog_clk edge while high.
- chanx_left_in  in  CHAN_WIDTH  tracks entering from the left.
- chanx_right_in  in  CHAN_WIDTH  tracks entering from the right.
- chanx_left_out  out  CHAN_WIDTH  tracks leaving to the left.
- chanx_right_out  out  CHAN_WIDTH  tracks leaving to the right.
- ipin_out  out  NUM_IPIN  grid input pin drives.
- ccff_tail  out  1  serial configuration data out, feeding the next block.
- cfg_done  out  1  high while state is CONF.

Behaviour:
- Pass-through (combinational, unaffected by state or reset):
  - chanx_right_out = chanx_left_in.
  - chanx_left_out = chanx_right_in.
- Chain register cfg[0:CHAIN_LEN-1]:
  - On each prog_clk edge with cfg_en=1: cfg[0] <= ccff_head, and cfg[k] <= cfg[k-1].
  - ccff_tail = cfg[CHAIN_LEN-1].
  - With cfg_en=0 the chain holds its value.
- Select decoding:
  - Ipin i select is sel_i = cfg[i*SEL_W +: SEL_W], LSB at the lower index.
  - Consequently the first bit shifted in ends up as the MSB of the last ipin.
- Mux inputs for ipin i, for j in 0..MUX_SIZE/2-1:
  - STRIDE = CHAN_WIDTH/(MUX_SIZE/2).
  - t = (i + j*STRIDE) mod CHAN_WIDTH.
  - in[2j] = chanx_left_in[t]; in[2j+1] = chanx_right_in[t].
  - ipin_out[i] = in[sel_i], combinational.
  - If GATE_UNCONF=1 and state != CONF, ipin_out[i] = 0.
- State machine (UNCONF, LOADING, CONF) with shift counter cnt, width $clog2(CHAIN_LEN+1):
  - UNCONF, cfg_en=1: shift, cnt <= 1, go to LOADING. If CHAIN_LEN==1, go directly to CONF.
  - LOADING, cfg_en=1: shift, cnt <= cnt+1. When cnt+1 == CHAIN_LEN, go to CONF and clear cnt.
  - LOADING, cfg_en=0: hold state, cnt and chain. A paused load resumes where it stopped.
  - CONF, cfg_en=1: reload. Shift, cnt <= 1, go to LOADING. cfg_done drops after that edge and outputs gate again.
  - CONF, cfg_en=0: hold.
- cfg_done:
  - Registered: equals (state == CONF).
  - Rises on the same edge as the final shift, so it is visible in the cycle after the CHAIN_LEN-th enabled edge.
- Reset (pReset low, any time, including mid-load):
  - Takes effect immediately and asynchronously.
  - cfg all 0, cnt 0, state UNCONF.
  - cfg_done 0, ccff_tail 0, ipin_out 0 (when gated).
  - Channel outputs keep following their inputs.
- No counter wrap: cnt never exceeds CHAIN_LEN-1.

Decomposition:
- Package cbx_param_pkg holds:
  - the state enum {UNCONF, LOADING, CONF};
  - the functions sel_w(mux_size) and track_idx(i, j, chan_width, mux_size).
- One natural sub-module: cbx_ipin_mux, a parametrised MUX_SIZE:1 binary-select mux, instantiated NUM_IPIN times by a generate loop.
- Chain and FSM stay in the top module.

Test Plan (configuration for all scenarios: CHAN_WIDTH=10, NUM_IPIN=4, MUX_SIZE=4, so CHAIN_LEN=8):
1. Reset: hold pReset low, drive random channel inputs.
   - Required: cfg_done=0, ccff_tail=0, ipin_out=4'b0.
   - Required: chanx_right_out == chanx_left_in and chanx_left_out == chanx_right_in every cycle.
2. Full load: cfg_en=1 for 8 edges with head sequence 0,0,1,1,0,1,1,0.
   - Required: cfg_done=1 after the 8th edge.
   - Required selects: sel0=2, sel1=1, sel2=3, sel3=0.
   - Required routing: ipin_out[0]=left[5], ipin_out[1]=right[1], ipin_out[2]=right[7], ipin_out[3]=left[3].
   - Check by toggling each source track individually.
3. Paused load: 3 enabled edges, cfg_en=0 for 5 cycles, then 5 more enabled edges.
   - Required: cfg_done stays 0 during the pause; the end result is identical to scenario 2.
   - Required: ipin_out=0 throughout the pause.
4. Reset mid-load: assert pReset after 4 shifts.
   - Required: immediate cfg_done=0, ccff_tail=0, ipin_out=0.
   - Required: a subsequent 8-bit load completes normally.
5. Reload and chain pass-through: from CONF, shift 8 more bits of all ones.
   - Required: cfg_done=0 after the first edge.
   - Required: ccff_tail emits the old contents 0,0,1,1,0,1,1,0 in order.
   - Required: cfg_done=1 after the 8th edge, with all selects = 3 (ipin_out[i] = right[(i+5) mod 10]).
6. GATE_UNCONF=0 variant: after reset, with no load.
   - Required: ipin_out[i] == left[i] (sel=0) immediately.

Source files
------------

// File: rtl/cbx_param_pkg.sv
// cbx_param_pkg: shared types and elaboration-time helpers for the parametrised X-channel connection block.
// Rev 1.0
`default_nettype none

package cbx_param_pkg;

  typedef enum logic [1:0] {
    UNCONF  = 2'd0,
    LOADING = 2'd1,
    CONF    = 2'd2
  } cfg_state_e;

  function automatic int sel_w(input int mux_size);
    return (mux_size < 2) ? 1 : $clog2(mux_size);
  endfunction

  // Track tapped by input pair j of ipin i; pairs are spread evenly across the channel.
  function automatic int track_idx(input int i, input int j, input int chan_width, input int mux_size);
    return (i + j * (chan_width / (mux_size / 2))) % chan_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cbx_ipin_mux.sv
// cbx_ipin_mux: MUX_SIZE:1 binary-select mux driving one grid input pin.
// Rev 1.0
`default_nettype none

module cbx_ipin_mux #(
  parameter int MUX_SIZE = 4,
  parameter int SEL_W    = 2
) (
  input  logic [MUX_SIZE-1:0] in_i,
  input  logic [SEL_W-1:0]    sel_i,
  output logic                out_o
);

  assign out_o = in_i[sel_i];

endmodule

`default_nettype wire

// File: rtl/cbx_param_cfg.sv
// cbx_param_cfg: parametrised X-channel connection block with its own serial configuration chain controller.
// Rev 1.0
`default_nettype none

module cbx_param_cfg
  import cbx_param_pkg::*;
#(
  parameter int CHAN_WIDTH  = 10,
  parameter int NUM_IPIN    = 11,
  parameter int MUX_SIZE    = 4,
  parameter int SEL_W       = sel_w(MUX_SIZE),
  parameter int CHAIN_LEN   = NUM_IPIN * SEL_W,
  parameter bit GATE_UNCONF = 1'b1
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  ccff_head,
  input  logic                  cfg_en,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  output logic [CHAN_WIDTH-1:0] chanx_left_out,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic [NUM_IPIN-1:0]   ipin_out,
  output logic                  ccff_tail,
  output logic                  cfg_done
);

  localparam int             CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam int             HALF     = MUX_SIZE / 2;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  logic [CHAIN_LEN-1:0] cfg_q, cfg_d;
  cfg_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 done_q;
  logic                 gate_ipins;

  assign chanx_right_out = chanx_left_in;
  assign chanx_left_out  = chanx_right_in;

  always_comb begin
    cfg_d = cfg_q;
    if (cfg_en) begin
      cfg_d[0] = ccff_head;
      for (int k = 1; k < CHAIN_LEN; k++) cfg_d[k] = cfg_q[k-1];
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) cfg_q <= '0;
    else         cfg_q <= cfg_d;
  end

  assign ccff_tail = cfg_q[CHAIN_LEN-1];

  // Any enabled edge outside LOADING starts a fresh load, including a reload from CONF.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q <= UNCONF;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (cfg_en) begin
      case (state_q)
        LOADING: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= CONF;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          if (CHAIN_LEN == 1) begin
            state_q <= CONF;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            state_q <= LOADING;
            cnt_q   <= CNT_ONE;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign cfg_done   = done_q;
  assign gate_ipins = GATE_UNCONF && (state_q != CONF);

  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
    logic [MUX_SIZE-1:0] mux_in;
    logic                mux_out;

    for (genvar j = 0; j < HALF; j++) begin : g_src
      localparam int T = track_idx(i, j, CHAN_WIDTH, MUX_SIZE);
      assign mux_in[2*j]   = chanx_left_in[T];
      assign mux_in[2*j+1] = chanx_right_in[T];
    end

    cbx_ipin_mux #(
      .MUX_SIZE(MUX_SIZE),
      .SEL_W   (SEL_W)
    ) u_mux (
      .in_i (mux_in),
      .sel_i(cfg_q[i*SEL_W +: SEL_W]),
      .out_o(mux_out)
    );

    assign ipin_out[i] = mux_out & ~gate_ipins;
  end

endmodule

`default_nettype wire
